// File: rtl/neo_count_cells.sv
// neo_count_cells: 4-bit loadable up-counter with cascade carry, plus a
// combinational delay buffer and a D flip-flop with complementary outputs.
//
// Ports
//   CLK_24MB  in   sole clock, rising edge
//   RESETP    in   asynchronous active-high reset
//   D[3:0]    in   counter parallel-load data
//   nLOAD     in   active-low synchronous load strobe
//   EN        in   count enable (parallel)
//   CI        in   carry in (trickle enable) for cascading
//   SCLR      in   synchronous clear (only with SYNC_CLEAR_EN defined)
//   Q[3:0]    out  counter value
//   CO        out  combinational carry out, CI & (Q == 4'hF)
//   BD_IN     in   delay-buffer input
//   BD_OUT    out  delay-buffer output (pure wire)
//   FD_D      in   flip-flop data
//   FD_Q      out  flip-flop true output
//   FD_nQ     out  flip-flop complement output
//
// Build option: define SYNC_CLEAR_EN to add the SCLR port and clear term.
// Counter priority per edge: SCLR > load > count > hold.

module neo_count_cells (
  input  logic       CLK_24MB,
  input  logic       RESETP,
  input  logic [3:0] D,
  input  logic       nLOAD,
  input  logic       EN,
  input  logic       CI,
`ifdef SYNC_CLEAR_EN
  input  logic       SCLR,
`endif
  output logic [3:0] Q,
  output logic       CO,
  input  logic       BD_IN,
  output logic       BD_OUT,
  input  logic       FD_D,
  output logic       FD_Q,
  output logic       FD_nQ
);

  logic [3:0] cnt_q, cnt_d;
  logic       fd_q;

  always_comb begin
    cnt_d = cnt_q;
`ifdef SYNC_CLEAR_EN
    if (SCLR) begin
      cnt_d = 4'h0;
    end else
`endif
    if (!nLOAD) begin
      cnt_d = D;
    end else if (EN && CI) begin
      cnt_d = cnt_q + 4'h1;  // wraps 15 -> 0 by width
    end
  end

  always_ff @(posedge CLK_24MB or posedge RESETP) begin
    if (RESETP) begin
      cnt_q <= 4'h0;
      fd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fd_q  <= FD_D;
    end
  end

  // Carry is unregistered so a chain of stages settles within one clock;
  // it is 0 in reset because the count is held at 0 there.
  assign Q      = cnt_q;
  assign CO     = CI & (cnt_q == 4'hF);
  assign BD_OUT = BD_IN;
  assign FD_Q   = fd_q;
  assign FD_nQ  = ~fd_q;

endmodule

// File: tb/tb_neo_count_cells.sv
module tb_neo_count_cells;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d_lo = 4'h0, d_hi = 4'h0;
  logic       nload_lo = 1'b1, nload_hi = 1'b1;
  logic       en = 1'b0, ci_lo = 1'b0;
  logic       sclr = 1'b0;
  logic [3:0] q_lo, q_hi;
  logic       co_lo, co_hi;
  logic       bd_in = 1'b0, bd_out, bd_out_hi;
  logic       fd_d = 1'b0, fd_q, fd_nq, fd_q_hi, fd_nq_hi;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_lo, m_hi, m_fd;

  always #5 clk = ~clk;

  neo_count_cells u_lo (
    .CLK_24MB (clk),
    .RESETP   (rst),
    .D        (d_lo),
    .nLOAD    (nload_lo),
    .EN       (en),
    .CI       (ci_lo),
`ifdef SYNC_CLEAR_EN
    .SCLR     (sclr),
`endif
    .Q        (q_lo),
    .CO       (co_lo),
    .BD_IN    (bd_in),
    .BD_OUT   (bd_out),
    .FD_D     (fd_d),
    .FD_Q     (fd_q),
    .FD_nQ    (fd_nq)
  );

  neo_count_cells u_hi (
    .CLK_24MB (clk),
    .RESETP   (rst),
    .D        (d_hi),
    .nLOAD    (nload_hi),
    .EN       (en),
    .CI       (co_lo),
`ifdef SYNC_CLEAR_EN
    .SCLR     (sclr),
`endif
    .Q        (q_hi),
    .CO       (co_hi),
    .BD_IN    (~bd_in),
    .BD_OUT   (bd_out_hi),
    .FD_D     (~fd_d),
    .FD_Q     (fd_q_hi),
    .FD_nQ    (fd_nq_hi)
  );

  function automatic int exp_co_lo();
    return (ci_lo && m_lo == 15) ? 1 : 0;
  endfunction

  function automatic int exp_co_hi();
    return (exp_co_lo() == 1 && m_hi == 15) ? 1 : 0;
  endfunction

  // Advance the model by one edge using the current inputs, then move to
  // 1 time unit after that edge.
  task automatic tick();
    int nlo, nhi, cin_hi;
    cin_hi = exp_co_lo();
    nlo = m_lo;
    nhi = m_hi;
    if (sclr) begin
      nlo = 0;
      nhi = 0;
    end else begin
      if (!nload_lo) nlo = d_lo;
      else if (en && ci_lo) nlo = (m_lo + 1) % 16;
      if (!nload_hi) nhi = d_hi;
      else if (en && cin_hi == 1) nhi = (m_hi + 1) % 16;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_lo = 0; m_hi = 0; m_fd = 0;
    end else begin
      m_lo = nlo; m_hi = nhi; m_fd = fd_d;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ci_lo = 1'b1; en = 1'b1; nload_lo = 1'b1; bd_in = 1'b1;
    @(posedge clk); #1;
    m_lo = 0; m_hi = 0; m_fd = 0;
    checks++;
    if (q_lo !== 4'h0) begin errors++; $display("FAIL reset_q got %0h want 0", q_lo); end
    checks++;
    if (fd_q !== 1'b0 || fd_nq !== 1'b1) begin
      errors++; $display("FAIL reset_fd got q=%b nq=%b want q=0 nq=1", fd_q, fd_nq);
    end
    checks++;
    if (co_lo !== 1'b0) begin errors++; $display("FAIL reset_co got %b want 0", co_lo); end
    bd_in = 1'b0; #1;
    checks++;
    if (bd_out !== 1'b0) begin errors++; $display("FAIL reset_bd got %b want 0", bd_out); end
    bd_in = 1'b1; #1;
    checks++;
    if (bd_out !== 1'b1) begin errors++; $display("FAIL reset_bd got %b want 1", bd_out); end
    rst = 1'b0; ci_lo = 1'b0; en = 1'b0;
  endtask

  task automatic test_load();
    d_lo = 4'hE; nload_lo = 1'b0; en = 1'b0; ci_lo = 1'b0;
    tick();
    checks++;
    if (q_lo !== 4'(m_lo) || m_lo != 14) begin
      errors++; $display("FAIL load got %0d want %0d", q_lo, m_lo);
    end
  endtask

  task automatic test_count_wrap();
    nload_lo = 1'b1; en = 1'b1; ci_lo = 1'b1;
    tick();
    checks++;
    if (q_lo !== 4'(m_lo) || co_lo !== 1'(exp_co_lo())) begin
      errors++; $display("FAIL count_to_15 got q=%0d co=%b want q=%0d co=%0d",
                         q_lo, co_lo, m_lo, exp_co_lo());
    end
    tick();
    checks++;
    if (q_lo !== 4'(m_lo) || co_lo !== 1'(exp_co_lo())) begin
      errors++; $display("FAIL wrap got q=%0d co=%b want q=%0d co=%0d",
                         q_lo, co_lo, m_lo, exp_co_lo());
    end
  endtask

  task automatic test_hold();
    d_lo = 4'hF; nload_lo = 1'b0;
    tick();
    nload_lo = 1'b1; en = 1'b1; ci_lo = 1'b0; #1;
    checks++;
    if (co_lo !== 1'b0) begin errors++; $display("FAIL hold_co got %b want 0", co_lo); end
    tick();
    checks++;
    if (q_lo !== 4'(m_lo)) begin errors++; $display("FAIL hold_q got %0d want %0d", q_lo, m_lo); end
    en = 1'b0; ci_lo = 1'b1;
    tick();
    checks++;
    if (q_lo !== 4'(m_lo)) begin errors++; $display("FAIL hold_en0 got %0d want %0d", q_lo, m_lo); end
  endtask

  task automatic test_cascade();
    d_lo = 4'hF; d_hi = 4'h3; nload_lo = 1'b0; nload_hi = 1'b0;
    tick();
    nload_lo = 1'b1; nload_hi = 1'b1; en = 1'b1; ci_lo = 1'b1; #1;
    checks++;
    if (co_lo !== 1'b1) begin errors++; $display("FAIL cascade_co got %b want 1", co_lo); end
    tick();
    checks++;
    if (q_lo !== 4'(m_lo) || q_hi !== 4'(m_hi)) begin
      errors++; $display("FAIL cascade got lo=%0d hi=%0d want lo=%0d hi=%0d",
                         q_lo, q_hi, m_lo, m_hi);
    end
    tick();
    checks++;
    if (q_hi !== 4'(m_hi)) begin errors++; $display("FAIL cascade_hold got hi=%0d want %0d", q_hi, m_hi); end
  endtask

  task automatic test_dff_buffer();
    logic [3:0] seq;
    seq = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      fd_d = seq[3-i];
      bd_in = $urandom_range(0, 1);
      #1;
      checks++;
      if (bd_out !== bd_in) begin errors++; $display("FAIL bd got %b want %b", bd_out, bd_in); end
      tick();
      checks++;
      if (fd_q !== 1'(m_fd) || fd_nq !== ~1'(m_fd)) begin
        errors++; $display("FAIL dff[%0d] got q=%b nq=%b want q=%0d", i, fd_q, fd_nq, m_fd);
      end
    end
  endtask

  task automatic test_reset_midcount();
    d_lo = 4'h8; nload_lo = 1'b0; fd_d = 1'b1;
    tick();
    nload_lo = 1'b1; en = 1'b1; ci_lo = 1'b1;
    tick();
    checks++;
    if (q_lo !== 4'd9 || m_lo != 9) begin errors++; $display("FAIL pre_reset got %0d want 9", q_lo); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (q_lo !== 4'h0 || fd_q !== 1'b0 || fd_nq !== 1'b1) begin
      errors++; $display("FAIL async_reset got q=%0d fq=%b fnq=%b want 0 0 1", q_lo, fd_q, fd_nq);
    end
    m_lo = 0; m_hi = 0; m_fd = 0;
    #1 rst = 1'b0;
    tick();
    checks++;
    if (q_lo !== 4'(m_lo) || m_lo != 1) begin
      errors++; $display("FAIL post_reset got %0d want %0d", q_lo, m_lo);
    end
  endtask

`ifdef SYNC_CLEAR_EN
  task automatic test_sync_clear();
    fd_d = 1'b1;
    tick();
    sclr = 1'b1; nload_lo = 1'b0; d_lo = 4'h5;
    tick();
    checks++;
    if (q_lo !== 4'(m_lo) || m_lo != 0) begin errors++; $display("FAIL sclr got %0d want 0", q_lo); end
    checks++;
    if (fd_q !== 1'b1) begin errors++; $display("FAIL sclr_fd got %b want 1", fd_q); end
    sclr = 1'b0; nload_lo = 1'b1;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      d_lo = 4'($urandom_range(0, 15));
      d_hi = 4'($urandom_range(0, 15));
      nload_lo = ($urandom_range(0, 7) != 0);
      nload_hi = ($urandom_range(0, 15) != 0);
      en = ($urandom_range(0, 3) != 0);
      ci_lo = ($urandom_range(0, 3) != 0);
      fd_d = $urandom_range(0, 1);
      bd_in = $urandom_range(0, 1);
`ifdef SYNC_CLEAR_EN
      sclr = ($urandom_range(0, 15) == 0);
`endif
      #1;
      checks++;
      if (co_lo !== 1'(exp_co_lo()) || co_hi !== 1'(exp_co_hi()) || bd_out !== bd_in) begin
        errors++; $display("FAIL rand_comb[%0d] got co=%b/%b bd=%b want co=%0d/%0d bd=%b",
                           i, co_lo, co_hi, bd_out, exp_co_lo(), exp_co_hi(), bd_in);
      end
      tick();
      checks++;
      if (q_lo !== 4'(m_lo) || q_hi !== 4'(m_hi) || fd_q !== 1'(m_fd) || fd_nq !== ~1'(m_fd)) begin
        errors++; $display("FAIL rand_seq[%0d] got lo=%0d hi=%0d fq=%b fnq=%b want lo=%0d hi=%0d fq=%0d",
                           i, q_lo, q_hi, fd_q, fd_nq, m_lo, m_hi, m_fd);
      end
    end
    sclr = 1'b0;
  endtask

  initial begin
    m_lo = 0; m_hi = 0; m_fd = 0;
    test_reset();
    test_load();
    test_count_wrap();
    test_hold();
    test_cascade();
    test_dff_buffer();
    test_reset_midcount();
`ifdef SYNC_CLEAR_EN
    test_sync_clear();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
